feature_nms_threshold: RTL and testbench



---
 rtl/feature_pkg.sv | 25 ++
 rtl/line_frame_counter.sv | 69 ++++++
 rtl/feature_nms_threshold.sv | 126 ++++++++++++
 tb/tb_feature_nms_threshold.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/feature_pkg.sv
// Shared pixel/sample types for the downsampled feature pipeline
// (five_by_five_window -> feature_nms_threshold -> UpsamplerWrap).
package feature_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   blank;
  } sample_t;

  localparam sample_t BLANK_SAMPLE = '{data: {PIX_W{1'b0}}, blank: 1'b1};

  // Thresholded 1x3 local maximum: strict against the left neighbour,
  // non-strict against the right one, so a plateau keeps only its first pixel.
  function automatic logic is_feature(input pixel_t c, input pixel_t l,
                                      input pixel_t r, input pixel_t thr);
    return (c >= thr) && (c > l) && (c >= r);
  endfunction

endpackage

// File: rtl/line_frame_counter.sv
// Column/row tracking for the valid-sample stream: detects line and frame ends,
// flags the threshold-capture point and latches a sticky line-length error.
module line_frame_counter
  import feature_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic valid_i,
  input  logic blank_i,
  output logic frame_end_o,
  output logic thr_capture_o,
  output logic length_error_o
);

  localparam int COL_W = $clog2(IMG_W + 2);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_MAX  = {COL_W{1'b1}};
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             err_q, err_d;
  logic             line_end_s;

  // A line ends at the first blanking sample after at least one active pixel.
  assign line_end_s     = valid_i && blank_i && (col_q != COL_ZERO);
  assign frame_end_o    = line_end_s && (row_q == ROW_LAST);
  assign thr_capture_o  = valid_i && !blank_i && (col_q == COL_ZERO) && (row_q == ROW_ZERO);
  assign length_error_o = err_q;

  // Next-state for column/row counters and the sticky length flag.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    if (valid_i && !blank_i) begin
      // Saturate so an overlong line can never wrap back to a legal count.
      col_d = (col_q == COL_MAX) ? col_q : col_q + COL_ONE;
    end else if (line_end_s) begin
      col_d = COL_ZERO;
      err_d = err_q | (col_q != COL_FULL);
      row_d = frame_end_o ? ROW_ZERO : row_q + ROW_ONE;
    end else begin
      col_d = col_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      col_q <= COL_ZERO;
      row_q <= ROW_ZERO;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/feature_nms_threshold.sv
// Threshold + horizontal 1x3 non-maximum suppression on the window stage's
// pixel stream, with a per-frame count of surviving features.
module feature_nms_threshold
  import feature_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] din,
  input  logic             blanking_in,
  input  logic             validin,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] dout,
  output logic             blanking_out,
  output logic             validout,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_features,
  output logic             length_error
);

  localparam pixel_t           PIX_ZERO = {PIX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  sample_t          new_s;
  pixel_t           right_s;
  logic             feat_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             frame_end_s;
  logic             thr_cap_s;

  sample_t          c_q, c_d;
  pixel_t           l_q, l_d;
  pixel_t           thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pixel_t           dout_q, dout_d;
  logic             blank_q, blank_d;
  logic             valid_q;
  logic             done_q, done_d;
  logic [CNT_W-1:0] feats_q, feats_d;

  line_frame_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_counter (
    .clock_i        (clock),
    .reset_i        (reset),
    .valid_i        (validin),
    .blank_i        (blanking_in),
    .frame_end_o    (frame_end_s),
    .thr_capture_o  (thr_cap_s),
    .length_error_o (length_error)
  );

  // The incoming sample is the right neighbour of the held centre pixel.
  assign new_s     = '{data: din, blank: blanking_in};
  assign right_s   = blanking_in ? PIX_ZERO : din;
  assign feat_s    = !c_q.blank && is_feature(c_q.data, l_q, right_s, thr_q);
  assign cnt_inc_s = {{(CNT_W-1){1'b0}}, feat_s};

  // Delay-line shift, decision output and feature tally on each accepted sample.
  always_comb begin
    c_d     = c_q;
    l_d     = l_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    dout_d  = PIX_ZERO;
    blank_d = blank_q;
    done_d  = 1'b0;
    feats_d = feats_q;
    if (validin) begin
      c_d     = new_s;
      l_d     = c_q.blank ? PIX_ZERO : c_q.data;
      blank_d = c_q.blank;
      dout_d  = feat_s ? c_q.data : PIX_ZERO;
      if (thr_cap_s) begin
        thr_d = thresh;
      end else begin
        thr_d = thr_q;
      end
      if (frame_end_s) begin
        feats_d = cnt_q + cnt_inc_s;
        cnt_d   = CNT_ZERO;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_inc_s;
      end
    end else begin
      dout_d = PIX_ZERO;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_q     <= BLANK_SAMPLE;
      l_q     <= PIX_ZERO;
      thr_q   <= PIX_ZERO;
      cnt_q   <= CNT_ZERO;
      dout_q  <= PIX_ZERO;
      blank_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      feats_q <= CNT_ZERO;
    end else begin
      c_q     <= c_d;
      l_q     <= l_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      blank_q <= blank_d;
      valid_q <= validin;
      done_q  <= done_d;
      feats_q <= feats_d;
    end
  end

  assign dout           = dout_q;
  assign blanking_out   = blank_q;
  assign validout       = valid_q;
  assign frame_done     = done_q;
  assign frame_features = feats_q;

endmodule

// File: tb/tb_feature_nms_threshold.sv
// Scoreboard bench for feature_nms_threshold on a reduced frame size.
module tb_feature_nms_threshold;

  localparam int W  = 48;
  localparam int H  = 10;
  localparam int CW = 17;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    din = 8'd0;
  logic          blanking_in = 1'b1;
  logic          validin = 1'b0;
  logic [7:0]    thresh = 8'd0;
  logic [7:0]    dout;
  logic          blanking_out;
  logic          validout;
  logic          frame_done;
  logic [CW-1:0] frame_features;
  logic          length_error;

  typedef struct {
    logic       b;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t sq[$];
  int   fq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   vin_cnt = 0;
  int   vout_cnt = 0;
  int   done_cnt = 0;

  feature_nms_threshold #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .din            (din),
    .blanking_in    (blanking_in),
    .validin        (validin),
    .thresh         (thresh),
    .dout           (dout),
    .blanking_out   (blanking_out),
    .validout       (validout),
    .frame_done     (frame_done),
    .frame_features (frame_features),
    .length_error   (length_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a sample or a frame end.
  exp_t e;
  int   ef;
  always @(negedge clock) begin
    if (validout) begin
      vout_cnt++;
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL spurious_out: got b=%0b d=%0d at cyc %0d, want no output", blanking_out, dout, cyc);
      end else begin
        e = sq.pop_front();
        if (blanking_out !== e.b || dout !== e.d || cyc != e.cyc) begin
          bad++;
          $display("FAIL out_sample: got b=%0b d=%0d cyc=%0d, want b=%0b d=%0d cyc=%0d",
                   blanking_out, dout, cyc, e.b, e.d, e.cyc);
        end
      end
    end
    if (frame_done) begin
      done_cnt++;
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL spurious_frame_done: got features=%0d, want no pulse", frame_features);
      end else begin
        ef = fq.pop_front();
        if (!validout || int'(frame_features) != ef) begin
          bad++;
          $display("FAIL frame_features: got %0d (validout=%0b), want %0d (validout=1)",
                   frame_features, validout, ef);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  task automatic send(input logic b, input logic [7:0] d,
                      input logic eb, input logic [7:0] ed, input int gap);
    exp_t x;
    repeat (gap) begin
      validin = 1'b0;
      @(posedge clock); #1;
    end
    validin = 1'b1;
    blanking_in = b;
    din = d;
    x.b = eb;
    x.d = ed;
    x.cyc = cyc + 1;
    sq.push_back(x);
    vin_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    validin = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    validin = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_blanking_out", int'(blanking_out), 1);
    chk("rst_validout", int'(validout), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_features", int'(frame_features), 0);
    chk("rst_length_error", int'(length_error), 0);
    reset = 1'b0;
  endtask

  // One frame, one peak of 100 per line on a floor of 1; peaks sweep both line edges.
  task automatic run_frame(input logic thr_change);
    int p;
    logic [7:0] v;
    for (int r = 0; r < H; r++) begin
      if (thr_change && r == H / 2) thresh = 8'd200;
      p = (r * (W - 1)) % W;
      for (int c = 0; c < W; c++) begin
        v = (c == p) ? 8'd100 : 8'd1;
        send(1'b0, v, (c == 0), (c > 0 && c - 1 == p) ? 8'd100 : 8'd0, $urandom_range(0, 2));
      end
      if (r == H - 1) fq.push_back(H);
      send(1'b1, 8'd0, 1'b0, (p == W - 1) ? 8'd100 : 8'd0, $urandom_range(0, 2));
    end
    send(1'b1, 8'd0, 1'b1, 8'd0, 0);
  endtask

  initial begin
    // Basic peak with phantom blanking first.
    do_reset();
    thresh = 8'd30;
    send(1'b0, 8'd10, 1'b1, 8'd0, 0);
    send(1'b0, 8'd50, 1'b0, 8'd0, 0);
    send(1'b0, 8'd20, 1'b0, 8'd50, 0);
    send(1'b1, 8'd0, 1'b0, 8'd0, 0);
    send(1'b1, 8'd0, 1'b1, 8'd0, 0);
    chk("short_line_length_error", int'(length_error), 1);

    // Plateau: only the first equal pixel survives.
    do_reset();
    thresh = 8'd0;
    send(1'b0, 8'd40, 1'b1, 8'd0, 0);
    send(1'b0, 8'd40, 1'b0, 8'd40, 1);
    send(1'b0, 8'd40, 1'b0, 8'd0, 0);
    send(1'b1, 8'd0, 1'b0, 8'd0, 2);
    send(1'b1, 8'd0, 1'b1, 8'd0, 0);

    // Final pixel equal to threshold with r = 0.
    do_reset();
    thresh = 8'd90;
    send(1'b0, 8'd5, 1'b1, 8'd0, 0);
    send(1'b0, 8'd90, 1'b0, 8'd0, 0);
    send(1'b1, 8'd0, 1'b0, 8'd90, 0);
    send(1'b1, 8'd0, 1'b1, 8'd0, 0);

    // Full frame with random gaps and a mid-frame threshold change.
    do_reset();
    thresh = 8'd30;
    run_frame(1'b1);
    idle(2);
    chk("frame_length_error", int'(length_error), 0);
    chk("frame_features_held", int'(frame_features), H);

    // Next frame: new threshold 200 applies; short line sets the sticky error.
    for (int c = 0; c < W - 1; c++)
      send(1'b0, (c == 3) ? 8'd100 : 8'd1, (c == 0), 8'd0, $urandom_range(0, 1));
    send(1'b1, 8'd0, 1'b0, 8'd0, 0);
    chk("length_error_set", int'(length_error), 1);
    for (int c = 0; c < W; c++)
      send(1'b0, 8'd1, (c == 0), 8'd0, 0);
    send(1'b1, 8'd0, 1'b0, 8'd0, 0);
    chk("length_error_sticky", int'(length_error), 1);
    chk("features_held_midframe", int'(frame_features), H);

    // Reset mid-line, then a fresh frame counts correctly.
    do_reset();
    thresh = 8'd30;
    for (int c = 0; c < 25; c++)
      send(1'b0, (c == 10) ? 8'd100 : 8'd1, (c == 0), (c > 0 && c - 1 == 10) ? 8'd100 : 8'd0, 0);
    do_reset();
    run_frame(1'b0);
    idle(4);

    chk("scoreboard_drained", sq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    chk("valid_count", vout_cnt, vin_cnt);
    chk("frame_done_count", done_cnt, 2);
    chk("final_features", int'(frame_features), H);
    chk("final_length_error", int'(length_error), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
